pc_target_unit: RTL and testbench
=================================

Name: pc_target_unit

Overview:
- Program-counter stage that sits directly downstream of the 1-bit left-shift stage.
- Consumes the word-scaled immediate and forms the branch target PC + (imm << 1).
- Resolves sequential, conditional-branch, register-jump and jump-and-link flow, then commits the next PC.
- Three-state FSM with a valid/ready handshake toward the control unit.

Parameters:
- WIDTH, 16, datapath and PC width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imm_shifted  input  WIDTH  word-scaled immediate from the left-shift stage; bit 0 is always 0.
- reg_target  input  WIDTH  register-sourced absolute target, used by JR/JAL.
- op_valid  input  1  control presents an operation this cycle.
- op_type  input  2  00 SEQ, 01 BRANCH, 10 JR, 11 JAL.
- cond_true  input  1  branch condition from the ALU compare; sampled only in COMMIT.
- op_ready  output  1  unit can accept an operation.
- pc  output  WIDTH  current program counter (registered).
- link_valid  output  1  one-cycle pulse; link_addr is valid.
- link_addr  output  WIDTH  return address (old PC + 2) for JAL.
- misalign  output  1  one-cycle pulse; a JR/JAL target had bit 0 set.
- commit  output  1  one-cycle pulse; pc updated this edge.

Behaviour:
- Reset (synchronous, active-high; clk/reset as named above):
  - pc = RESET_PC; state = IDLE; op_ready = 1.
  - link_valid, misalign and commit = 0; link_addr = 0; latched registers cleared.
  - Reset in any state aborts the operation in flight; no commit pulse is produced.
- FSM states: IDLE, CALC, COMMIT.
- IDLE:
  - op_ready = 1.
  - Accept when op_valid = 1: latch op_type, imm_shifted and reg_target; go to CALC.
  - op_valid = 0: stay in IDLE; pc holds.
- CALC:
  - op_ready = 0.
  - tgt_rel = pc + imm_latched, modulo 2^WIDTH; wrap-around silently discarded.
  - seq = pc + 2, modulo 2^WIDTH; latch both.
  - Unconditional transition to COMMIT.
- COMMIT:
  - op_ready = 0.
  - Next PC selection:
    - SEQ: pc <= seq.
    - BRANCH: pc <= tgt_rel if cond_true, else seq.
    - JR: pc <= {reg_latched[WIDTH-1:1], 1'b0}.
    - JAL: same target as JR; link_addr <= seq; link_valid = 1 for exactly this cycle.
  - misalign pulses when JR/JAL reg_latched[0] = 1. The jump still proceeds with bit 0 cleared.
  - commit pulses high; unconditional transition to IDLE.
- Latency:
  - Operation accepted at edge N; pc changes at edge N+2 (visible after it).
  - Next accept at edge N+3 at the earliest; throughput is one operation per 3 cycles.
- Input stability: op_valid, imm_shifted and reg_target are ignored outside IDLE. Changes during CALC or COMMIT have no effect.
- Immediate sign: imm_shifted is treated as two's complement, so negative offsets branch backward. Example: pc 0x0010 + 0xFFFC = 0x000C.
- Wrap-around: pc 0xFFFE with SEQ gives 0x0000; pc 0xFFF0 + 0x0020 gives 0x0010.
- link_addr holds its last value until the next JAL.

Optional Feature:
- Macro: BRANCH_COUNT_EN.
- Defined:
  - Extra output port taken_count [15:0] and extra input count_clr.
  - taken_count increments on each commit where BRANCH with cond_true, JR or JAL is taken.
  - Saturates at 16'hFFFF.
  - Cleared by reset or count_clr; count_clr wins over a simultaneous increment.
- Undefined: the taken_count and count_clr ports and the counter logic are absent.

Test Plan:
- Reset then SEQ from pc 0x0000 -> op_ready low for 2 cycles; commit pulse; pc = 0x0002 two edges after accept.
- BRANCH, pc 0x0010, imm_shifted 0x0008, cond_true = 1 in COMMIT -> pc = 0x0018. Repeat with cond_true = 0 -> pc = 0x0012.
- BRANCH backward, pc 0x0010, imm_shifted 0xFFFC, cond_true = 1 -> pc = 0x000C. From pc 0xFFFE, SEQ -> pc = 0x0000.
- JAL, pc 0x0040, reg_target 0x1235 -> pc = 0x1234; link_valid and misalign both pulse 1 cycle; link_addr = 0x0042.
- Change op_valid/imm_shifted during CALC -> result unchanged. Assert reset during CALC -> pc = RESET_PC, no commit pulse, op_ready = 1 next cycle.
- With BRANCH_COUNT_EN: 3 taken and 1 not-taken branch -> taken_count = 3; count_clr with a simultaneous taken branch -> taken_count = 0.

Source files
------------

// File: rtl/pc_target_unit.sv
// rtl/pc_target_unit.sv - next-PC resolution for SEQ/BRANCH/JR/JAL (optional BRANCH_COUNT_EN taken counter)
module pc_target_unit #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] imm_shifted,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             op_valid,
   input  logic [1:0]       op_type,
   input  logic             cond_true,
   output logic             op_ready,
   output logic [WIDTH-1:0] pc,
   output logic             link_valid,
   output logic [WIDTH-1:0] link_addr,
   output logic             misalign,
`ifdef BRANCH_COUNT_EN
   input  logic             count_clr,
   output logic [15:0]      taken_count,
`endif
   output logic             commit
);

   localparam logic [1:0] OP_SEQ    = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_JR     = 2'b10;
   localparam logic [1:0] OP_JAL    = 2'b11;

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_CALC   = 2'b01,
      S_COMMIT = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [1:0]       r_op_type;
   logic [WIDTH-1:0] r_imm;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] r_tgt_rel;
   logic [WIDTH-1:0] r_seq;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_link_addr;

   logic [WIDTH-1:0] w_next_pc;
   logic [WIDTH-1:0] w_jump_tgt;
   logic             w_op_ready;
   logic             w_commit;
   logic             w_link_valid;
   logic             w_misalign;
   logic             w_taken;

   // Register targets are forced halfword-aligned; a set bit 0 only raises misalign.
   assign w_jump_tgt = {r_reg[WIDTH-1:1], 1'b0};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, handshake, pulse outputs and next-PC selection.
   always_comb begin
      w_next_state = r_state;
      w_op_ready   = 1'b0;
      w_commit     = 1'b0;
      w_link_valid = 1'b0;
      w_misalign   = 1'b0;
      w_taken      = 1'b0;
      w_next_pc    = r_pc;
      case (r_state)
         S_IDLE: begin
            w_op_ready = 1'b1;
            if (op_valid) begin
               w_next_state = S_CALC;
            end
         end
         S_CALC: begin
            w_next_state = S_COMMIT;
         end
         S_COMMIT: begin
            w_commit     = 1'b1;
            w_next_state = S_IDLE;
            case (r_op_type)
               OP_SEQ: begin
                  w_next_pc = r_seq;
               end
               OP_BRANCH: begin
                  if (cond_true) begin
                     w_next_pc = r_tgt_rel;
                     w_taken   = 1'b1;
                  end else begin
                     w_next_pc = r_seq;
                  end
               end
               OP_JR: begin
                  w_next_pc  = w_jump_tgt;
                  w_misalign = r_reg[0];
                  w_taken    = 1'b1;
               end
               default: begin
                  w_next_pc    = w_jump_tgt;
                  w_misalign   = r_reg[0];
                  w_link_valid = 1'b1;
                  w_taken      = 1'b1;
               end
            endcase
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Pulses are suppressed while reset is held so an aborted commit never shows.
   assign op_ready   = reset | w_op_ready;
   assign commit     = w_commit & ~reset;
   assign link_valid = w_link_valid & ~reset;
   assign misalign   = w_misalign & ~reset;
   assign pc         = r_pc;
   assign link_addr  = r_link_addr;

   // Operand latch, target arithmetic and PC/link commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_type   <= OP_SEQ;
         r_imm       <= '0;
         r_reg       <= '0;
         r_tgt_rel   <= '0;
         r_seq       <= '0;
         r_pc        <= RESET_PC;
         r_link_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (op_valid) begin
                  r_op_type <= op_type;
                  r_imm     <= imm_shifted;
                  r_reg     <= reg_target;
               end
            end
            S_CALC: begin
               r_tgt_rel <= r_pc + r_imm;
               r_seq     <= r_pc + PC_STEP;
            end
            S_COMMIT: begin
               r_pc <= w_next_pc;
               if (r_op_type == OP_JAL) begin
                  r_link_addr <= r_seq;
               end
            end
            default: begin
               r_pc <= r_pc;
            end
         endcase
      end
   end

`ifdef BRANCH_COUNT_EN
   logic [15:0] r_taken_count;

   // Saturating count of taken control transfers; clear beats increment.
   always_ff @(posedge clk) begin
      if (reset || count_clr) begin
         r_taken_count <= '0;
      end else if (w_taken && (r_taken_count != 16'hFFFF)) begin
         r_taken_count <= r_taken_count + 16'd1;
      end
   end

   assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_target_unit.sv
// tb/tb_pc_target_unit.sv - directed self-checking bench for pc_target_unit
module tb_pc_target_unit;

   localparam logic [1:0] OP_SEQ    = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_JR     = 2'b10;
   localparam logic [1:0] OP_JAL    = 2'b11;

   logic        clk;
   logic        reset;
   logic [15:0] imm_shifted;
   logic [15:0] reg_target;
   logic        op_valid;
   logic [1:0]  op_type;
   logic        cond_true;
   logic        op_ready;
   logic [15:0] pc;
   logic        link_valid;
   logic [15:0] link_addr;
   logic        misalign;
   logic        commit;
`ifdef BRANCH_COUNT_EN
   logic        count_clr;
   logic [15:0] taken_count;
`endif

   int n_checks;
   int n_errors;

   pc_target_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imm_shifted (imm_shifted),
      .reg_target  (reg_target),
      .op_valid    (op_valid),
      .op_type     (op_type),
      .cond_true   (cond_true),
      .op_ready    (op_ready),
      .pc          (pc),
      .link_valid  (link_valid),
      .link_addr   (link_addr),
      .misalign    (misalign),
`ifdef BRANCH_COUNT_EN
      .count_clr   (count_clr),
      .taken_count (taken_count),
`endif
      .commit      (commit)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full operation: accept, CALC, COMMIT; optionally disturbs inputs during CALC.
   task automatic do_op(input logic [1:0] op, input logic [15:0] imm, input logic [15:0] rt,
                        input logic cond, input logic perturb, input logic [15:0] exp_pc,
                        input logic exp_lv, input logic exp_mis);
      op_type     = op;
      imm_shifted = imm;
      reg_target  = rt;
      op_valid    = 1'b1;
      check("idle_ready", op_ready, 1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (perturb) begin
         op_valid    = 1'b1;
         imm_shifted = ~imm;
         reg_target  = ~rt;
         op_type     = ~op;
      end
      check("calc_ready", op_ready, 0);
      check("calc_commit", commit, 0);
      @(posedge clk); #1;
      op_valid  = 1'b0;
      cond_true = cond;
      check("commit_ready", op_ready, 0);
      check("commit_pulse", commit, 1);
      check("link_valid", link_valid, exp_lv);
      check("misalign", misalign, exp_mis);
      @(posedge clk); #1;
      cond_true = 1'b0;
      check("pc", pc, exp_pc);
      check("post_commit", commit, 0);
      check("post_link_valid", link_valid, 0);
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      imm_shifted = '0;
      reg_target  = '0;
      op_valid    = 1'b0;
      op_type     = OP_SEQ;
      cond_true   = 1'b0;
`ifdef BRANCH_COUNT_EN
      count_clr   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_pc", pc, 16'h0000);
      check("rst_ready", op_ready, 1);
      check("rst_commit", commit, 0);
      check("rst_link_valid", link_valid, 0);
      check("rst_misalign", misalign, 0);
      check("rst_link_addr", link_addr, 16'h0000);

      // Sequential step from reset PC.
      do_op(OP_SEQ, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      // Forward branch taken / not taken.
      do_op(OP_JR, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0008, 16'h0000, 1'b1, 1'b0, 16'h0018, 1'b0, 1'b0);
      do_op(OP_JR, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0008, 16'h0000, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0);

      // Backward branch.
      do_op(OP_JR, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'hFFFC, 16'h0000, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0);

      // Wrap-around on SEQ and on branch.
      do_op(OP_JR, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      do_op(OP_SEQ, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      do_op(OP_JR, 16'h0000, 16'hFFF0, 1'b0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

      // JAL with misaligned register target.
      do_op(OP_JR, 16'h0000, 16'h0040, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0);
      check("link_before_jal", link_addr, 16'h0000);
      do_op(OP_JAL, 16'h0000, 16'h1235, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1);
      check("jal_link_addr", link_addr, 16'h0042);
      do_op(OP_SEQ, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1236, 1'b0, 1'b0);
      check("link_addr_hold", link_addr, 16'h0042);

      // Inputs disturbed during CALC must not alter the result.
      do_op(OP_JR, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0008, 16'h0000, 1'b1, 1'b1, 16'h0018, 1'b0, 1'b0);

      // Reset during CALC aborts the operation.
      op_type  = OP_SEQ;
      op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("abort_calc_ready", op_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_pc", pc, 16'h0000);
      check("abort_ready", op_ready, 1);
      check("abort_commit", commit, 0);
      @(posedge clk); #1;
      check("abort_commit_later", commit, 0);
      check("abort_pc_later", pc, 16'h0000);

`ifdef BRANCH_COUNT_EN
      count_clr = 1'b1;
      @(posedge clk); #1;
      count_clr = 1'b0;
      check("cnt_clr", taken_count, 0);
      do_op(OP_BRANCH, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0);
      do_op(OP_BRANCH, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
      check("cnt_three", taken_count, 3);
      op_type     = OP_BRANCH;
      imm_shifted = 16'h0002;
      op_valid    = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(posedge clk); #1;
      cond_true = 1'b1;
      count_clr = 1'b1;
      @(posedge clk); #1;
      cond_true = 1'b0;
      count_clr = 1'b0;
      check("cnt_clr_wins", taken_count, 0);
      check("cnt_clr_pc", pc, 16'h000A);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
